// File: rtl/systolic_pkg.sv
// Shared constants for the systolic processing element: mode encodings and
// the default accumulator width rule.
package systolic_pkg;

  localparam logic MODE_WS = 1'b0;  // weight-stationary
  localparam logic MODE_OS = 1'b1;  // output-stationary

  // Default accumulator width: full product plus 4 guard bits for summation.
  function automatic int acc_width_default(input int data_width);
    return 2 * data_width + 4;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Signed add with either saturation or two's-complement wrap; ovf flags that
// the true sum did not fit in ACC_WIDTH bits.
module sat_add #(
  parameter int ACC_WIDTH = 12,
  parameter bit SAT       = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0] a,
  input  logic signed [ACC_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        ovf
);

  logic signed [ACC_WIDTH:0] w_wide;

  assign w_wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
  // Top two bits disagree exactly when the result left the ACC_WIDTH range.
  assign ovf    = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

  // Clamp toward the sign of the true result when saturating, else wrap.
  always_comb begin
    sum = w_wide[ACC_WIDTH-1:0];
    if (SAT && ovf)
      sum = w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/systolic_pe.sv
// Systolic array processing element. Weight-stationary mode keeps a
// double-buffered weight and adds its product onto the partial sum flowing
// through; output-stationary mode accumulates locally and drains on request.
// Every output is a register, one cycle behind its inputs.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH),
  parameter bit SAT        = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_val,
  input  logic signed [DATA_WIDTH-1:0] in_weight,
  input  logic                         weight_shift,
  input  logic                         weight_swap,
  input  logic signed [ACC_WIDTH-1:0]  in_sum,
  input  logic                         drain,
  input  logic                         clear_acc,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_val,
  output logic signed [DATA_WIDTH-1:0] out_weight,
  output logic                         out_weight_shift,
  output logic                         out_weight_swap,
  output logic signed [ACC_WIDTH-1:0]  out_sum,
  output logic                         out_sat
);

  localparam int PW = 2 * DATA_WIDTH;

  if (ACC_WIDTH < PW) begin : g_bad_width
    $error("systolic_pe: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  logic signed [DATA_WIDTH-1:0] r_shadow;
  logic signed [DATA_WIDTH-1:0] r_active;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_mode_prev;

  logic                         w_is_os;
  logic                         w_mode_chg;
  logic signed [PW-1:0]         w_ws_prod;
  logic signed [PW-1:0]         w_os_prod;
  logic signed [ACC_WIDTH-1:0]  w_ws_ext;
  logic signed [ACC_WIDTH-1:0]  w_os_ext;
  logic signed [ACC_WIDTH-1:0]  w_os_base;
  logic signed [ACC_WIDTH-1:0]  w_ws_sum;
  logic signed [ACC_WIDTH-1:0]  w_os_sum;
  logic                         w_ws_ovf;
  logic                         w_os_ovf;
  logic                         w_ovf;

  assign w_is_os    = (mode == MODE_OS);
  assign w_mode_chg = (mode != r_mode_prev);

  // Full-precision products, sign-extended before entering the adder.
  assign w_ws_prod  = in_val * r_active;
  assign w_os_prod  = in_val * in_weight;
  assign w_ws_ext   = ACC_WIDTH'(w_ws_prod);
  assign w_os_ext   = ACC_WIDTH'(w_os_prod);

  // Drain, clear or a mode change restart accumulation from zero, so a beat
  // arriving in the same cycle becomes the first term of the new sum.
  assign w_os_base  = (w_mode_chg || drain || clear_acc) ? '0 : r_acc;

  sat_add #(.ACC_WIDTH(ACC_WIDTH), .SAT(SAT)) u_ws_add (
    .a   (in_sum),
    .b   (w_ws_ext),
    .sum (w_ws_sum),
    .ovf (w_ws_ovf)
  );

  sat_add #(.ACC_WIDTH(ACC_WIDTH), .SAT(SAT)) u_os_add (
    .a   (w_os_base),
    .b   (w_os_ext),
    .sum (w_os_sum),
    .ovf (w_os_ovf)
  );

  assign w_ovf = in_valid & (w_is_os ? w_os_ovf : w_ws_ovf);

  // Weight buffers, accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow         <= '0;
      r_active         <= '0;
      r_acc            <= '0;
      r_mode_prev      <= MODE_WS;
      out_valid        <= 1'b0;
      out_val          <= '0;
      out_weight       <= '0;
      out_weight_shift <= 1'b0;
      out_weight_swap  <= 1'b0;
      out_sum          <= '0;
      out_sat          <= 1'b0;
    end else begin
      out_valid   <= in_valid;
      out_val     <= in_val;
      r_mode_prev <= mode;
      // A fresh overflow wins over clear_acc so it is never lost.
      out_sat     <= (clear_acc ? 1'b0 : out_sat) | w_ovf;

      if (w_is_os) begin
        out_weight_shift <= 1'b0;
        out_weight_swap  <= 1'b0;
        if (in_valid) begin
          r_acc      <= w_os_sum;
          out_weight <= in_weight;
        end else begin
          r_acc      <= w_os_base;
        end
        if (drain)
          out_sum <= w_mode_chg ? '0 : r_acc;
        else
          out_sum <= in_sum;
      end else begin
        out_weight_shift <= weight_shift;
        out_weight_swap  <= weight_swap;
        // Both use the pre-edge shadow, so shift+swap loads the old shadow.
        if (weight_shift) begin
          r_shadow   <= in_weight;
          out_weight <= r_shadow;
        end
        if (weight_swap)
          r_active <= r_shadow;
        if (in_valid)
          out_sum <= w_ws_sum;
        if (w_mode_chg || clear_acc)
          r_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe: a saturating and a wrapping instance share
// stimulus; expected outputs are queued per step and compared after the edge.
module tb_systolic_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode, in_valid, weight_shift, weight_swap, drain, clear_acc;
  logic [3:0]  in_val, in_weight;
  logic [11:0] in_sum;

  logic        vld_s, wsh_s, wsw_s, sat_s;
  logic [3:0]  val_s, wt_s;
  logic [11:0] sum_s;
  logic        vld_w, wsh_w, wsw_w, sat_w;
  logic [3:0]  val_w, wt_w;
  logic [11:0] sum_w;

  typedef struct {
    string      tag;
    logic       v;
    logic [11:0] ss;
    logic       sats;
    logic [11:0] sw;
    logic       satw;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  systolic_pe #(.DATA_WIDTH(4), .ACC_WIDTH(12), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
    .in_val(in_val), .in_weight(in_weight), .weight_shift(weight_shift),
    .weight_swap(weight_swap), .in_sum(in_sum), .drain(drain),
    .clear_acc(clear_acc), .out_valid(vld_s), .out_val(val_s),
    .out_weight(wt_s), .out_weight_shift(wsh_s), .out_weight_swap(wsw_s),
    .out_sum(sum_s), .out_sat(sat_s)
  );

  systolic_pe #(.DATA_WIDTH(4), .ACC_WIDTH(12), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
    .in_val(in_val), .in_weight(in_weight), .weight_shift(weight_shift),
    .weight_swap(weight_swap), .in_sum(in_sum), .drain(drain),
    .clear_acc(clear_acc), .out_valid(vld_w), .out_val(val_w),
    .out_weight(wt_w), .out_weight_shift(wsh_w), .out_weight_swap(wsw_w),
    .out_sum(sum_w), .out_sat(sat_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic v, input int ss, input logic sats,
                      input int sw, input logic satw);
    exp_t e;
    e.tag = tag; e.v = v; e.ss = 12'(ss); e.sats = sats; e.sw = 12'(sw); e.satw = satw;
    q.push_back(e);
  endtask

  // Advance one edge, then retire the expectation queued for it.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.tag, ".valid"},  32'(vld_s), 32'(e.v));
      chk({e.tag, ".valid_w"}, 32'(vld_w), 32'(e.v));
      chk({e.tag, ".sum_sat"}, 32'(sum_s), 32'(e.ss));
      chk({e.tag, ".sum_wrap"}, 32'(sum_w), 32'(e.sw));
      chk({e.tag, ".sat_sat"}, 32'(sat_s), 32'(e.sats));
      chk({e.tag, ".sat_wrap"}, 32'(sat_w), 32'(e.satw));
    end
  endtask

  task automatic idle();
    in_valid = 0; weight_shift = 0; weight_swap = 0; drain = 0; clear_acc = 0;
  endtask

  task automatic beat(input int v, input int w, input int s);
    in_valid = 1; in_val = 4'(v); in_weight = 4'(w); in_sum = 12'(s);
  endtask

  initial begin
    // Reset overrides random activity on every input.
    reset = 0; mode = 1'($urandom); in_valid = 1; weight_shift = 1; weight_swap = 1;
    drain = 1; clear_acc = 0; in_val = 4'($urandom); in_weight = 4'($urandom);
    in_sum = 12'($urandom);
    push("rst", 0, 0, 0, 0, 0); tick();
    chk("rst.val", 32'(val_s), 0);
    chk("rst.wt", 32'(wt_s), 0);
    chk("rst.wsh", 32'(wsh_s), 0);
    chk("rst.wsw", 32'(wsw_w), 0);

    // WS: shift 3, swap, then -2*3+5.
    reset = 1; mode = 0; idle(); in_val = 0; in_sum = 0;
    weight_shift = 1; in_weight = 3;
    push("ws_shift", 0, 0, 0, 0, 0); tick();
    chk("ws_shift.osh", 32'(wsh_s), 1);
    chk("ws_shift.owt", 32'(wt_s), 0);
    idle(); weight_swap = 1;
    push("ws_swap", 0, 0, 0, 0, 0); tick();
    chk("ws_swap.osw", 32'(wsw_s), 1);
    idle(); beat(-2, 0, 5);
    push("ws_mac", 1, -1, 0, -1, 0); tick();
    chk("ws_mac.val", 32'(val_s), 32'h0000000E);

    // Double buffer.
    idle(); weight_shift = 1; in_weight = 7;
    push("db_shift7", 0, -1, 0, -1, 0); tick();
    chk("db_shift7.owt", 32'(wt_s), 3);
    idle(); beat(1, 0, 0);
    push("db_still3", 1, 3, 0, 3, 0); tick();
    idle(); weight_shift = 1; weight_swap = 1; in_weight = 5;
    push("db_shswap", 0, 3, 0, 3, 0); tick();
    chk("db_shswap.owt", 32'(wt_s), 7);
    idle(); beat(1, 0, 0);
    push("db_act7", 1, 7, 0, 7, 0); tick();
    idle(); weight_swap = 1;
    push("db_swap5", 0, 7, 0, 7, 0); tick();
    idle(); beat(1, 0, 0);
    push("db_shadow5", 1, 5, 0, 5, 0); tick();
    idle(); weight_shift = 1; in_weight = 7;
    push("ld7", 0, 5, 0, 5, 0); tick();
    idle(); weight_swap = 1;
    push("sw7", 0, 5, 0, 5, 0); tick();

    // Saturation and sticky flag.
    idle(); beat(7, 0, 2040);
    push("sat_pos", 1, 2047, 1, -2007, 1); tick();
    idle(); beat(0, 0, 1);
    push("sat_sticky", 1, 1, 1, 1, 1); tick();
    idle(); clear_acc = 1;
    push("sat_clr", 0, 1, 0, 1, 0); tick();
    idle(); clear_acc = 1; beat(7, 0, 2040);
    push("sat_clr_ovf", 1, 2047, 1, -2007, 1); tick();
    idle(); clear_acc = 1;
    push("sat_clr2", 0, 2047, 0, -2007, 0); tick();
    idle(); beat(-1, 0, -2048);
    push("sat_neg", 1, -2048, 1, 2041, 1); tick();
    idle(); clear_acc = 1;
    push("sat_clr3", 0, -2048, 0, 2041, 0); tick();

    // OS accumulate and drain; WS chain inputs are ignored here.
    idle(); mode = 1; in_sum = 0; weight_shift = 1; weight_swap = 1;
    push("os_enter", 0, 0, 0, 0, 0); tick();
    chk("os_enter.osh", 32'(wsh_s), 0);
    chk("os_enter.osw", 32'(wsw_s), 0);
    idle(); beat(1, 2, 0);   push("os_b1", 1, 0, 0, 0, 0); tick();
    beat(-3, 4, 100);        push("os_pass", 1, 100, 0, 100, 0); tick();
    beat(5, -6, 0);          push("os_b3", 1, 0, 0, 0, 0); tick();
    beat(7, 7, 0);           push("os_b4", 1, 0, 0, 0, 0); tick();
    chk("os_b4.owt", 32'(wt_s), 7);
    idle(); drain = 1;       push("os_drain9", 0, 9, 0, 9, 0); tick();
    idle(); drain = 1;       push("os_drain0", 0, 0, 0, 0, 0); tick();
    idle(); beat(1, 2, 0);   push("os_c1", 1, 0, 0, 0, 0); tick();
    beat(-3, 4, 0);          push("os_c2", 1, 0, 0, 0, 0); tick();
    beat(5, -6, 0);          push("os_c3", 1, 0, 0, 0, 0); tick();
    beat(7, 7, 0);           push("os_c4", 1, 0, 0, 0, 0); tick();
    idle(); drain = 1; beat(2, 3, 0);
    push("os_drain_beat", 1, 9, 0, 9, 0); tick();
    idle(); drain = 1;       push("os_drain6", 0, 6, 0, 6, 0); tick();

    // Mode switch clears acc but keeps weights.
    idle(); beat(1, 2, 0);   push("ms_b1", 1, 0, 0, 0, 0); tick();
    beat(-3, 4, 0);          push("ms_b2", 1, 0, 0, 0, 0); tick();
    beat(5, -6, 0);          push("ms_b3", 1, 0, 0, 0, 0); tick();
    beat(7, 7, 0);           push("ms_b4", 1, 0, 0, 0, 0); tick();
    idle(); mode = 0; beat(1, 0, 0);
    push("ms_ws_w7", 1, 7, 0, 7, 0); tick();
    idle(); mode = 1; in_sum = 0;
    push("ms_back", 0, 0, 0, 0, 0); tick();
    idle(); drain = 1;       push("ms_acc0", 0, 0, 0, 0, 0); tick();

    // Reset mid-accumulation, then normal operation resumes.
    idle(); beat(1, 2, 0);   push("rm_b1", 1, 0, 0, 0, 0); tick();
    beat(1, 2, 0);           push("rm_b2", 1, 0, 0, 0, 0); tick();
    reset = 0; drain = 1; beat(3, 3, 0);
    push("rm_rst", 0, 0, 0, 0, 0); tick();
    chk("rm_rst.owt", 32'(wt_w), 0);
    chk("rm_rst.val", 32'(val_w), 0);
    reset = 1; idle(); drain = 1;
    push("rm_drain", 0, 0, 0, 0, 0); tick();
    idle(); beat(3, 3, 0);   push("rm_b3", 1, 0, 0, 0, 0); tick();
    idle(); drain = 1;       push("rm_drain9", 0, 9, 0, 9, 0); tick();

    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
